// File: rtl/mul_share_arbiter.sv
// Shared multiplier with round-robin arbitration across NREQ requesters.
// One operation is in flight at a time: grant in IDLE, LATENCY cycles in
// EXEC, then the product is held in DONE until the consumer takes it.
module mul_share_arbiter #(
    parameter int DATAWIDTH = 64,
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int LATENCY   = 2
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATAWIDTH-1:0] req_a,
    input  logic [NREQ*DATAWIDTH-1:0] req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      resp_valid,
    output logic [DATAWIDTH-1:0]      resp_prod,
    output logic [IDW-1:0]            resp_id,
    input  logic                      resp_ready,
    output logic                      busy
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state, state_nx;
    logic [IDW-1:0]                  rr_ptr;
    logic [CW-1:0]                   count;
    logic [DATAWIDTH-1:0]            a_r, b_r;
    logic [IDW-1:0]                  id_r;

    // Per-requester view of the flat operand buses.
    logic [NREQ-1:0][DATAWIDTH-1:0]  a_vec, b_vec;
    assign a_vec = req_a;
    assign b_vec = req_b;

    logic                            grant_any;
    logic [IDW-1:0]                  grant_id;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int k;
        grant_any = 1'b0;
        grant_id  = '0;
        k         = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!grant_any && req_valid[k]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(k);
            end
        end
    end

    // State register; reset returns to IDLE and drops any op in flight.
    always_ff @(posedge Clk) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state and the one-cycle accept pulse to the granted requester.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        case (state)
            IDLE: if (grant_any) begin
                req_ready = NREQ'(1) << grant_id;
                state_nx  = EXEC;
            end
            EXEC: if (count == '0) state_nx = DONE;
            DONE: if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, latency countdown, response hold and pointer update.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            rr_ptr     <= '0;
            count      <= '0;
            a_r        <= '0;
            b_r        <= '0;
            id_r       <= '0;
            resp_valid <= 1'b0;
            resp_prod  <= '0;
            resp_id    <= '0;
        end else begin
            case (state)
                IDLE: if (grant_any) begin
                    a_r   <= a_vec[grant_id];
                    b_r   <= b_vec[grant_id];
                    id_r  <= grant_id;
                    count <= CW'(LATENCY - 1);
                end
                EXEC: if (count != '0) begin
                    count <= count - CW'(1);
                end else begin
                    // Unsigned product truncated to the operand width.
                    resp_prod  <= a_r * b_r;
                    resp_id    <= id_r;
                    resp_valid <= 1'b1;
                end
                DONE: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    // Just-served requester drops to lowest priority.
                    rr_ptr     <= (id_r == IDW'(NREQ - 1)) ? '0 : id_r + IDW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter against a transaction-level model:
// the model keeps at most one outstanding op with its grant time, and
// derives grants, response timing and products from plain arithmetic.
module tb_mul_share_arbiter;

    localparam int DW   = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 2;

    logic                 Clk = 1'b0;
    logic                 Rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_a, req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid;
    logic [DW-1:0]        resp_prod;
    logic [IDW-1:0]       resp_id;
    logic                 resp_ready;
    logic                 busy;

    mul_share_arbiter #(.DATAWIDTH(DW), .NREQ(NREQ), .IDW(IDW), .LATENCY(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_prod(resp_prod),
        .resp_id(resp_id), .resp_ready(resp_ready), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int nvec = 0;
    int nerr = 0;

    // Requester-side stimulus state.
    logic [NREQ-1:0] vv;
    logic [DW-1:0]   va [NREQ];
    logic [DW-1:0]   vb [NREQ];
    bit              hold;

    // Model state: one outstanding op, its grant cycle and its product.
    bit              have_op;
    int              op_t, op_id, ptr, last_id, last_grant, cyc;
    logic [DW-1:0]   op_p, last_p;
    int              grants[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return 64'h8000_0000_0000_0000;
            2:       return {$urandom, $urandom};
            default: return DW'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic int pick();
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (ptr + i) % NREQ;
            if (vv[k]) return k;
        end
        return -1;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step();
        int            g;
        bit            exp_valid;
        logic [127:0]  full;
        req_valid = vv;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = va[i];
            req_b[i*DW +: DW] = vb[i];
        end
        #1;
        g         = have_op ? -1 : pick();
        exp_valid = have_op && (cyc >= op_t + LAT + 1);
        chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
        chk("busy", 64'(busy), 64'(have_op));
        chk("resp_valid", 64'(resp_valid), 64'(exp_valid));
        if (exp_valid) begin
            last_p  = op_p;
            last_id = op_id;
        end
        chk("resp_prod", resp_prod, last_p);
        chk("resp_id", 64'(resp_id), 64'(last_id));
        @(posedge Clk);
        if (!Rst) begin
            have_op = 0; ptr = 0; last_p = '0; last_id = 0;
        end else if (g >= 0) begin
            full       = {64'd0, va[g]} * {64'd0, vb[g]};
            have_op    = 1;
            op_t       = cyc;
            op_p       = full[DW-1:0];
            op_id      = g;
            last_grant = g;
            grants.push_back(g);
            if (hold) begin va[g] = rnd(); vb[g] = rnd(); end
            else vv[g] = 1'b0;
        end else if (exp_valid && resp_ready) begin
            have_op = 0;
            ptr     = (op_id + 1) % NREQ;
        end
        cyc++;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst = 1'b0; vv = '0; resp_ready = 1'b0;
        step();
        Rst = 1'b1;
        grants.delete();
        last_grant = -1;
    endtask

    task automatic run_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] expp);
        vv = '0; vv[i] = 1'b1; va[i] = a; vb[i] = b; resp_ready = 1'b1;
        step();
        for (int s = 0; s < LAT; s++) step();
        #1;
        chk("op_valid", 64'(resp_valid), 64'd1);
        chk("op_prod", resp_prod, expp);
        chk("op_id", 64'(resp_id), 64'(i));
        step();
    endtask

    initial begin
        Rst = 1'b0; resp_ready = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        vv = '0; hold = 0; cyc = 0;
        for (int i = 0; i < NREQ; i++) begin va[i] = '0; vb[i] = '0; end
        have_op = 0; ptr = 0; op_t = 0; op_id = 0; op_p = '0;
        last_p = '0; last_id = 0; last_grant = -1;
        @(posedge Clk);
        @(negedge Clk);
        do_reset();

        // Basic latency and product, then truncating overflow.
        run_op(0, 64'd3, 64'd5, 64'd15);
        run_op(0, 64'h8000_0000_0000_0000, 64'd2, 64'd0);
        run_op(0, '1, '1, 64'd1);

        // All four held: strict rotation 0,1,2,3,0.
        do_reset();
        hold = 1; vv = '1; resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin va[i] = rnd(); vb[i] = rnd(); end
        for (int s = 0; s < 5 * (LAT + 2); s++) step();
        hold = 0;
        chk("rot_count", 64'(grants.size() >= 5), 64'd1);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            chk("rot_order", 64'(grants[i]), 64'(i % NREQ));

        // Backpressure in DONE with other requesters waiting.
        do_reset();
        vv = 4'b0110; resp_ready = 1'b0;
        va[1] = 64'd7; vb[1] = 64'd9; va[2] = rnd(); vb[2] = rnd();
        for (int s = 0; s < LAT + 1 + 5; s++) step();
        chk("bp_holder", 64'(last_grant), 64'd1);
        resp_ready = 1'b1;
        for (int s = 0; s < LAT + 3; s++) step();

        // Reset during EXEC aborts the op; pointer restarts at 0.
        do_reset();
        vv = 4'b0001; va[0] = 64'd11; vb[0] = 64'd13; resp_ready = 1'b1;
        step();
        Rst = 1'b0; vv = '0;
        step();
        Rst = 1'b1; last_grant = -1;
        vv = 4'b1010; va[1] = 64'd4; vb[1] = 64'd6; va[3] = rnd(); vb[3] = rnd();
        step();
        chk("rst_grant", 64'(last_grant), 64'd1);
        for (int s = 0; s < LAT + 2; s++) step();

        // Requester 0 held; requester 2 arrives mid-op and must go next.
        do_reset();
        hold = 1; vv = 4'b0001; va[0] = rnd(); vb[0] = rnd(); resp_ready = 1'b1;
        step();
        vv[2] = 1'b1; va[2] = rnd(); vb[2] = rnd();
        for (int s = 0; s < LAT + 2; s++) step();
        chk("fair_next", 64'(last_grant), 64'd2);
        hold = 0;
        vv = '0;
        for (int s = 0; s < LAT + 2; s++) step();

        // Random traffic with occasional resets and backpressure.
        for (int s = 0; s < 3000; s++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (vv[i] && $urandom_range(0, 19) == 0) vv[i] = 1'b0;
                else if (!vv[i] && $urandom_range(0, 3) == 0) begin
                    vv[i] = 1'b1; va[i] = rnd(); vb[i] = rnd();
                end
            end
            resp_ready = ($urandom_range(0, 2) != 0);
            Rst        = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
